fetch_stream_unit: RTL and testbench
====================================

// Module: fetch_stream_unit
// PURPOSE
//   Parametrised instruction-fetch stage; successor to the single-cycle fetch path. Owns the PC,
//   issues one outstanding request at a time to a variable-latency instruction memory, buffers
//   returned words in a small FIFO and presents them to decode with valid/ready. Supports
//   redirects (branch/jump) with flush, halt, and sticky error reporting. Sits between the PC/branch
//   logic and decode; multi-cycle memory (stalling memory/cache) hangs off the mem_* port.
// PARAMETERS
//   DATA_W      16      instruction width
//   ADDR_W      16      PC / memory address width
//   RESET_PC    16'h0   PC value after reset
//   PC_INC      2       sequential PC increment (bytes per instruction)
//   FIFO_DEPTH  2       instruction buffer entries (power of two, >=2)
// PORTS
//   clk            in   1       clock, all state on rising edge
//   rst            in   1       asynchronous reset, active-low (0 = reset)
//   redirect_valid in   1       load redirect_pc into PC and flush (sampled at edge)
//   redirect_pc    in   ADDR_W  redirect target
//   halt           in   1       stop issuing new requests (sticky once sampled)
//   mem_req        out  1       request active; held with mem_addr stable until mem_done
//   mem_addr       out  ADDR_W  fetch address (= current PC while mem_req)
//   mem_done       in   1       response valid this cycle (earliest: cycle after mem_req first high)
//   mem_rdata      in   DATA_W  returned instruction, valid with mem_done
//   mem_err        in   1       error qualifier on response, valid with mem_done
//   instr_valid    out  1       FIFO head valid
//   instr_ready    in   1       decode accepts head this cycle
//   instr          out  DATA_W  FIFO head instruction (0 when empty)
//   instr_pc       out  ADDR_W  PC of head instruction (0 when empty)
//   fetch_pc       out  ADDR_W  current PC register
//   err            out  1       sticky error
// BEHAVIOUR
//   Reset (rst=0, async): PC=RESET_PC, FIFO empty, state IDLE, mem_req=0, mem_addr=RESET_PC,
//     instr_valid=0, instr=0, instr_pc=0, err=0. Reset mid-request abandons it; mem_req drops at once.
//   States: IDLE, WAIT, DROP, HALTED, ERROR.
//     IDLE  : if count<FIFO_DEPTH and !halt -> assert mem_req (registered), go WAIT.
//     WAIT  : on mem_done: push {mem_rdata, PC}; PC<=PC+PC_INC (mod 2^ADDR_W, wraps);
//             go IDLE (or back-to-back WAIT with new PC if count after push < DEPTH and !halt).
//     DROP  : outstanding response belongs to a flushed PC; on mem_done discard it, go IDLE.
//     HALTED: no requests; FIFO still drains; exits only via reset.
//     ERROR : mem_req=0, err=1; FIFO drains; exits only via reset.
//   Redirect (highest priority after reset): FIFO flushed same edge, PC<=redirect_pc;
//     if WAIT without mem_done that cycle -> DROP, else -> IDLE. Redirect with mem_done in same
//     cycle discards the response. Redirect ignored in HALTED/ERROR.
//   redirect_pc[0]=1 (misaligned, PC_INC=2) -> ERROR. mem_done with mem_err=1 -> ERROR, word not pushed.
//   halt sampled in IDLE/WAIT: in-flight request completes and is pushed, then HALTED.
//   FIFO: push and pop same cycle -> count unchanged; pop when empty ignored; never push when full
//     (issue gated by count<DEPTH, single outstanding guarantees room).
//   Latency: redirect at edge N -> mem_req high cycle N+1 -> mem_done earliest N+2 ->
//     instr_valid high cycle N+3. Steady-state with 1-cycle memory: one instr per 2 cycles.
//   mem_addr/mem_req are registered; mem_addr must not change while mem_req=1 and mem_done=0.
// TESTING
//   Reset release, memory done 1 cycle after req, ready=1 -> instr_pc sequence 0,2,4,6; first valid cycle 3.
//   instr_ready=0 for 10 cycles, DEPTH=2 -> exactly 2 entries buffered, mem_req stays 0, no word lost.
//   Redirect to 16'h0040 while WAIT (done 3 cycles later) -> old word dropped, next instr_pc=16'h0040.
//   Redirect to 16'h0041 -> err=1 next cycle, mem_req=0 thereafter until rst=0.
//   PC=16'hFFFE sequential fetch -> next fetch_pc=16'h0000 (wrap).
//   Assert rst=0 mid-WAIT -> mem_req, instr_valid low immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stream_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a variable-latency
// instruction memory, and buffers returned words in a small FIFO toward decode.
module fetch_stream_unit #(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       PC_INC     = 2,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              err
);
    localparam int unsigned       PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_INC - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DROP,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                err_q, err_d;
    logic                halt_seen_q, halt_seen_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   fifo_instr_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_instr_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_pc_q    [FIFO_DEPTH];
    logic [ADDR_W-1:0]   fifo_pc_d    [FIFO_DEPTH];

    logic                push;
    logic                flush;
    logic                pop;
    logic                halt_now;
    logic                outstanding;
    logic [ADDR_W-1:0]   pc_next;
    logic [CNT_W-1:0]    cnt_after_push;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign fetch_pc    = pc_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign err         = err_q;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        err_d          = err_q;
        halt_seen_d    = halt_seen_q | halt;
        push           = 1'b0;
        flush          = 1'b0;
        pc_next        = pc_q + PC_STEP;
        cnt_after_push = count_q + CNT_W'(1) - CNT_W'(pop);
        halt_now       = halt | halt_seen_q;
        // A request is still in flight unless its response lands this very cycle.
        outstanding    = ((state_q == S_WAIT) || (state_q == S_DROP)) && !mem_done;

        if ((state_q == S_HALTED) || (state_q == S_ERROR)) begin
            mem_req_d = 1'b0;
        end else if (redirect_valid) begin
            if ((redirect_pc & ALIGN_MASK) != '0) begin
                state_d   = S_ERROR;
                mem_req_d = 1'b0;
                err_d     = 1'b1;
            end else begin
                // Keep the old request on the bus until memory answers, then discard it.
                flush     = 1'b1;
                pc_d      = redirect_pc;
                mem_req_d = outstanding;
                state_d   = outstanding ? S_DROP : S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (halt_now) begin
                        state_d = S_HALTED;
                    end else if (count_q < DEPTH_C) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        if (mem_err) begin
                            state_d   = S_ERROR;
                            mem_req_d = 1'b0;
                            err_d     = 1'b1;
                        end else begin
                            push = 1'b1;
                            pc_d = pc_next;
                            if (!halt_now && (cnt_after_push < DEPTH_C)) begin
                                mem_addr_d = pc_next;
                            end else begin
                                mem_req_d = 1'b0;
                                state_d   = halt_now ? S_HALTED : S_IDLE;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = mem_rdata;
                fifo_pc_d[wr_ptr_q]    = pc_q;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= RESET_PC;
            err_q       <= 1'b0;
            halt_seen_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            err_q       <= err_d;
            halt_seen_q <= halt_seen_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Buffer storage needs no reset; visibility is governed by count_q.
    always_ff @(posedge clk) begin
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

endmodule

// File: tb/tb_fetch_stream_unit.sv
// Bench for fetch_stream_unit: randomized memory responder and decode backpressure, with a
// transaction-level program-order model feeding a scoreboard queue.
module tb_fetch_stream_unit;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 16;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int unsigned PC_INC     = 2;
    localparam int unsigned FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] fetch_pc;
    logic        err;

    fetch_stream_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC),
        .PC_INC(PC_INC), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .fetch_pc(fetch_pc), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    // reference model state
    logic [15:0] model_pc = RESET_PC;
    int          epoch = 0;
    bit          model_err = 0;
    bit          model_halt = 0;
    bit          halt_settled = 0;

    // memory responder state
    bit          busy = 0;
    int          cnt = 0;
    logic [15:0] req_addr = '0;
    int          req_epoch = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          err_en = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        halt_settled   = 0;
        err_en         = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (instr_valid) break;
            tick();
        end
        if (i == 40) note_fail({name, "_timeout"});
    endtask

    task automatic wait_req(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            if (mem_req) break;
            tick();
        end
        if (i == 40) note_fail({name, "_timeout"});
    endtask

    // Model: delivered words follow program order from the latest redirect; anything
    // requested before an accepted redirect is discarded, an erroring response ends the stream.
    initial begin
        bit redir;
        bit live;
        forever begin
            @(posedge clk);
            if (!rst) begin
                exp_q.delete();
                model_pc   = RESET_PC;
                epoch++;
                model_err  = 0;
                model_halt = 0;
                continue;
            end
            redir = 0;
            if (redirect_valid && !model_err && !halt_settled) begin
                redir = 1;
                if (redirect_pc % PC_INC != 0) begin
                    model_err = 1;
                end else begin
                    exp_q.delete();
                    model_pc = redirect_pc;
                    epoch++;
                end
            end
            live = mem_done && busy && !redir && !model_err && (req_epoch == epoch);
            if (live) begin
                if (mem_err) begin
                    model_err = 1;
                end else begin
                    check("resp_addr", 32'(req_addr), 32'(model_pc));
                    exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
                    model_pc = model_pc + 16'(PC_INC);
                end
            end
            if (halt) model_halt = 1;
        end
    end

    // Memory responder: answers each request after a random latency of lat_min..lat_max cycles.
    initial begin
        bit consumed;
        forever begin
            @(posedge clk);
            #1;
            consumed  = mem_done;
            mem_done  = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = 16'($urandom);
            if (!rst) begin
                busy = 0;
                continue;
            end
            if (consumed) busy = 0;
            if (busy && !mem_req) busy = 0;
            if (busy) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(req_addr));
                cnt--;
                if (cnt <= 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = mem_word(req_addr);
                    mem_err   = err_en && ($urandom_range(0, 149) == 0);
                end
            end else if (mem_req) begin
                busy      = 1;
                req_addr  = mem_addr;
                req_epoch = epoch;
                cnt       = int'($urandom_range(lat_min, lat_max));
                if (model_halt) note_fail("issue_after_halt");
            end
        end
    end

    // Monitor: compares the decode-side interface against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) continue;
            check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            check("fetch_pc", 32'(fetch_pc), 32'(model_pc));
            check("err", 32'(err), 32'(model_err));
            if (model_err || halt_settled || exp_q.size() >= FIFO_DEPTH)
                check("mem_req_blocked", 32'(mem_req), 32'd0);
            if (exp_q.size() > FIFO_DEPTH) note_fail("fifo_overflow");
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_instr");
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(e.pc));
                    check("instr", 32'(instr), 32'(e.data));
                end
            end else if (!instr_valid) begin
                check("instr_empty_zero", 32'(instr), 32'd0);
                check("instr_pc_empty_zero", 32'(instr_pc), 32'd0);
            end
        end
    end

    initial begin
        // Reset state and first-fetch latency with a 1-cycle memory.
        lat_min     = 1;
        lat_max     = 1;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(RESET_PC));
        check("rst_fetch_pc", 32'(fetch_pc), 32'(RESET_PC));
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("lat_req_c1", 32'(mem_req), 32'd1);
        check("lat_valid_c1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_c2", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_c3", 32'(instr_valid), 32'd1);
        check("lat_first_pc", 32'(instr_pc), 32'(RESET_PC));
        repeat (8) tick();

        // Backpressure: buffer fills to depth and fetching stops without losing words.
        instr_ready = 1'b0;
        repeat (10) tick();
        check("bp_mem_req", 32'(mem_req), 32'd0);
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_entry0", 32'(instr_valid), 32'd1);
        @(negedge clk);
        check("bp_entry1", 32'(instr_valid), 32'd1);
        @(negedge clk);
        check("bp_empty", 32'(instr_valid), 32'd0);

        // Redirect while a slow request is outstanding: its word must be dropped.
        lat_min = 3;
        lat_max = 3;
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                tick();
                if (mem_req && busy && cnt >= 2) break;
            end
            if (i == 40) note_fail("drop_setup_timeout");
        end
        pulse_redirect(16'h0040);
        wait_valid("drop_valid");
        check("drop_next_pc", 32'(instr_pc), 32'h0040);
        repeat (4) tick();

        // Sequential wrap at the top of the address space.
        lat_min = 1;
        lat_max = 1;
        pulse_redirect(16'hFFFE);
        wait_valid("wrap_valid0");
        check("wrap_pc0", 32'(instr_pc), 32'hFFFE);
        check("wrap_fetch_pc", 32'(fetch_pc), 32'h0000);
        tick();
        wait_valid("wrap_valid1");
        check("wrap_pc1", 32'(instr_pc), 32'h0000);

        // Randomized traffic: latency, backpressure, redirects (some misaligned), memory errors.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            lat_min = 1;
            lat_max = 3;
            err_en  = 1;
            for (int c = 0; c < 300; c++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    redirect_pc = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) redirect_pc[15:3] = 13'h1FFF;
                    redirect_pc[0] = ($urandom_range(0, 9) == 0);
                    redirect_valid = 1'b1;
                end else begin
                    redirect_valid = 1'b0;
                end
                tick();
            end
            redirect_valid = 1'b0;
        end

        // Halt: in-flight request completes, then no more requests; redirects ignored.
        do_reset();
        lat_min = 1;
        lat_max = 3;
        for (int c = 0; c < 20; c++) begin
            instr_ready = ($urandom_range(0, 1) != 0);
            tick();
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        repeat (8) tick();
        halt_settled = 1;
        check("halt_no_req", 32'(mem_req), 32'd0);
        pulse_redirect(16'h0100);
        instr_ready = 1'b1;
        repeat (10) tick();
        check("halt_drained", 32'(instr_valid), 32'd0);
        check("halt_redirect_ignored_pc", 32'(fetch_pc), 32'(model_pc));

        // Misaligned redirect raises the sticky error and stops fetching.
        do_reset();
        lat_min     = 1;
        lat_max     = 1;
        instr_ready = 1'b1;
        repeat (6) tick();
        pulse_redirect(16'h0041);
        check("mis_err", 32'(err), 32'd1);
        repeat (5) tick();
        check("mis_err_sticky", 32'(err), 32'd1);
        check("mis_no_req", 32'(mem_req), 32'd0);

        // Asynchronous reset in the middle of a request.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        wait_req("rstmid_req");
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(mem_req), 32'd0);
        check("rstmid_valid", 32'(instr_valid), 32'd0);
        check("rstmid_fetch_pc", 32'(fetch_pc), 32'(RESET_PC));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        wait_req("restart_req");
        check("restart_addr", 32'(mem_addr), 32'(RESET_PC));
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
